// File: rtl/spi_flash_target.sv
// spi_flash_target: mode-0 SPI responder that emulates the read side of a boot flash.
// Every SPI pin is oversampled in the clk domain (clk must be at least 8x sclk).
// Commands: 0x03 READ, 0x9F JEDEC ID and 0x05 READ STATUS. Any other command is ignored.
// Optional feature macro SPI_TARGET_FAST_READ_EN: when defined, 0x0B FAST READ is decoded
// with 8 dummy clocks. When undefined, 0x0B is ignored like any other unknown command.
module spi_flash_target #(
   parameter logic [23:0] JEDEC_ID = 24'hEF4018,
   parameter int unsigned ADDR_W   = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata
);

   localparam int unsigned CNT_W      = 5;
   localparam int unsigned SHIFT_W    = 23;
   localparam logic [7:0]  CMD_READ   = 8'h03;
   localparam logic [7:0]  CMD_JEDEC  = 8'h9F;
   localparam logic [7:0]  CMD_STATUS = 8'h05;
`ifdef SPI_TARGET_FAST_READ_EN
   localparam logic [7:0]  CMD_FAST   = 8'h0B;
`endif

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
`ifdef SPI_TARGET_FAST_READ_EN
      ST_DUMMY,
`endif
      ST_DATA,
      ST_ID,
      ST_STAT,
      ST_IGNORE
   } state_t;

   // synchronizer and edge-detect registers
   logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
   logic cs_meta_q,   cs_sync_q,   cs_prev_q;
   logic mosi_meta_q, mosi_sync_q;

   // protocol registers
   state_t             state_q;
   logic [CNT_W-1:0]   bit_cnt_q;
   logic [SHIFT_W-1:0] shift_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [7:0]         tx_q;
   logic [1:0]         id_idx_q;
   logic               load_q;
   logic               miso_q;
   logic               miso_oe_q;
   logic               mem_rd_q;
`ifdef SPI_TARGET_FAST_READ_EN
   logic               fast_q;
`endif

   logic              sclk_rise_c;
   logic              sclk_fall_c;
   logic              cs_fall_c;
   logic [23:0]       shift_in_c;
   logic [ADDR_W-1:0] addr_cap_c;

   // Two-flop synchronizers. The chip-select stages reset to the asserted level so that a
   // select already held low across reset is never mistaken for a new falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_meta_q <= 1'b0;
         sclk_sync_q <= 1'b0;
         sclk_prev_q <= 1'b0;
         cs_meta_q   <= 1'b0;
         cs_sync_q   <= 1'b0;
         cs_prev_q   <= 1'b0;
         mosi_meta_q <= 1'b0;
         mosi_sync_q <= 1'b0;
      end else begin
         sclk_meta_q <= sclk;
         sclk_sync_q <= sclk_meta_q;
         sclk_prev_q <= sclk_sync_q;
         cs_meta_q   <= cs_n;
         cs_sync_q   <= cs_meta_q;
         cs_prev_q   <= cs_sync_q;
         mosi_meta_q <= mosi;
         mosi_sync_q <= mosi_meta_q;
      end
   end

   // edge detection and the incoming shift word including the bit being sampled now
   always_comb begin
      sclk_rise_c = sclk_sync_q & ~sclk_prev_q;
      sclk_fall_c = ~sclk_sync_q & sclk_prev_q;
      cs_fall_c   = ~cs_sync_q & cs_prev_q;
      shift_in_c  = {shift_q, mosi_sync_q};
      addr_cap_c  = shift_in_c[ADDR_W-1:0];
   end

   // protocol FSM with registered miso/miso_oe/mem_rd/mem_addr
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= CNT_W'(0);
         shift_q   <= SHIFT_W'(0);
         addr_q    <= ADDR_W'(0);
         tx_q      <= 8'h00;
         id_idx_q  <= 2'd0;
         load_q    <= 1'b0;
         miso_q    <= 1'b0;
         miso_oe_q <= 1'b0;
         mem_rd_q  <= 1'b0;
`ifdef SPI_TARGET_FAST_READ_EN
         fast_q    <= 1'b0;
`endif
      end else begin
         mem_rd_q <= 1'b0;
         load_q   <= mem_rd_q;
         if (cs_sync_q) begin
            // deselect wins over any sclk edge seen in the same cycle
            state_q   <= ST_IDLE;
            bit_cnt_q <= CNT_W'(0);
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            load_q    <= 1'b0;
         end else begin
            if (sclk_fall_c && miso_oe_q) begin
               miso_q <= tx_q[7];
               tx_q   <= {tx_q[6:0], 1'b0};
            end
            if (load_q && (state_q == ST_DATA)) begin
               tx_q <= mem_rdata;
            end
            if (sclk_rise_c) begin
               shift_q   <= shift_in_c[SHIFT_W-1:0];
               bit_cnt_q <= bit_cnt_q + CNT_W'(1);
               case (state_q)
                  ST_CMD: begin
                     if (bit_cnt_q == CNT_W'(7)) begin
                        bit_cnt_q <= CNT_W'(0);
                        case (shift_in_c[7:0])
                           CMD_READ: begin
                              state_q <= ST_ADDR;
`ifdef SPI_TARGET_FAST_READ_EN
                              fast_q  <= 1'b0;
`endif
                           end
`ifdef SPI_TARGET_FAST_READ_EN
                           CMD_FAST: begin
                              state_q <= ST_ADDR;
                              fast_q  <= 1'b1;
                           end
`endif
                           CMD_JEDEC: begin
                              state_q   <= ST_ID;
                              tx_q      <= JEDEC_ID[23:16];
                              id_idx_q  <= 2'd1;
                              miso_oe_q <= 1'b1;
                           end
                           CMD_STATUS: begin
                              state_q   <= ST_STAT;
                              tx_q      <= 8'h00;
                              miso_oe_q <= 1'b1;
                           end
                           default: state_q <= ST_IGNORE;
                        endcase
                     end
                  end
                  ST_ADDR: begin
                     if (bit_cnt_q == CNT_W'(23)) begin
                        bit_cnt_q <= CNT_W'(0);
                        addr_q    <= addr_cap_c;
`ifdef SPI_TARGET_FAST_READ_EN
                        if (fast_q) begin
                           state_q <= ST_DUMMY;
                        end else begin
                           state_q   <= ST_DATA;
                           mem_rd_q  <= 1'b1;
                           miso_oe_q <= 1'b1;
                        end
`else
                        state_q   <= ST_DATA;
                        mem_rd_q  <= 1'b1;
                        miso_oe_q <= 1'b1;
`endif
                     end
                  end
`ifdef SPI_TARGET_FAST_READ_EN
                  ST_DUMMY: begin
                     if (bit_cnt_q == CNT_W'(7)) begin
                        bit_cnt_q <= CNT_W'(0);
                        state_q   <= ST_DATA;
                        mem_rd_q  <= 1'b1;
                        miso_oe_q <= 1'b1;
                     end
                  end
`endif
                  ST_DATA: begin
                     if (bit_cnt_q == CNT_W'(7)) begin
                        bit_cnt_q <= CNT_W'(0);
                        addr_q    <= addr_q + ADDR_W'(1);
                        mem_rd_q  <= 1'b1;
                     end
                  end
                  ST_ID: begin
                     if (bit_cnt_q == CNT_W'(7)) begin
                        bit_cnt_q <= CNT_W'(0);
                        case (id_idx_q)
                           2'd1:    tx_q <= JEDEC_ID[15:8];
                           2'd2:    tx_q <= JEDEC_ID[7:0];
                           default: tx_q <= 8'h00;
                        endcase
                        if (id_idx_q != 2'd3) begin
                           id_idx_q <= id_idx_q + 2'd1;
                        end
                     end
                  end
                  ST_STAT: begin
                     if (bit_cnt_q == CNT_W'(7)) begin
                        bit_cnt_q <= CNT_W'(0);
                        tx_q      <= 8'h00;
                     end
                  end
                  default: bit_cnt_q <= CNT_W'(0);
               endcase
            end
            if ((state_q == ST_IDLE) && cs_fall_c) begin
               state_q   <= ST_CMD;
               bit_cnt_q <= CNT_W'(0);
            end
         end
      end
   end

   assign miso     = miso_q;
   assign miso_oe  = miso_oe_q;
   assign mem_rd   = mem_rd_q;
   assign mem_addr = addr_q;

endmodule
